// File: rtl/counter_blip_pkg.sv
// Shared constants and Gray-code helpers for the isolator blip-detection counter.
// gray2bin is provided for receive-side checkers and benches.
package counter_blip_pkg;

    localparam int COUNT_WIDTH_DEFAULT = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] value);
        return value ^ (value >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/blip_prescaler.sv
// Step-tick generator: tick is high for one cycle every PRESCALE clk cycles.
// With PRESCALE=1 the tick is tied high and no flops are built.
module blip_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = clk ^ reset;
            assign tick = 1'b1;
        end else begin : g_divider
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
            logic [CW-1:0] phase;

            assign tick = (phase == LAST);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    phase <= '0;
                end else if (tick) begin
                    phase <= '0;
                end else begin
                    phase <= phase + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/counter_for_isolator_blip_detection.sv
// Free-running pattern counter driven across a galvanic isolator for blip detection.
// Define COUNT_GRAY_EN to emit the Gray-coded count instead of plain binary.
module counter_for_isolator_blip_detection
    import counter_blip_pkg::*;
#(
    parameter int WIDTH    = COUNT_WIDTH_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    logic             tick;
    logic [WIDTH-1:0] bin_p0;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] count_next;

    blip_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign bin_next = bin_p0 + {{(WIDTH - 1){1'b0}}, tick};

    // Output encoding is taken from the next binary value so both registers update together.
`ifdef COUNT_GRAY_EN
    assign count_next = WIDTH'(bin2gray(32'(bin_next)));
`else
    assign count_next = bin_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_p0 <= '0;
            count  <= '0;
        end else begin
            bin_p0 <= bin_next;
            count  <= count_next;
        end
    end

endmodule

// File: tb/tb_counter_for_isolator_blip_detection.sv
// Directed bench: three instances (8-bit/step 1, 8-bit/step 4, 4-bit/step 1) share clk and reset.
// Honors COUNT_GRAY_EN for the expected output encoding.
module tb_counter_for_isolator_blip_detection;
    import counter_blip_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] count8;
    logic [7:0] count_p4;
    logic [3:0] count_w4;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    logic [7:0] prev8;

    counter_for_isolator_blip_detection #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .count(count8)
    );
    counter_for_isolator_blip_detection #(.WIDTH(8), .PRESCALE(4)) dut_p4 (
        .clk(clk), .reset(reset), .count(count_p4)
    );
    counter_for_isolator_blip_detection #(.WIDTH(4), .PRESCALE(1)) dut_w4 (
        .clk(clk), .reset(reset), .count(count_w4)
    );

    initial clk = 1'b1;
    always #15 clk = ~clk;

    function automatic logic [7:0] enc8(input int v);
        logic [7:0] b;
        b = 8'(v % 256);
`ifdef COUNT_GRAY_EN
        return b ^ {1'b0, b[7:1]};
`else
        return b;
`endif
    endfunction

    function automatic logic [7:0] enc4(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
`ifdef COUNT_GRAY_EN
        return {4'b0, b ^ {1'b0, b[3:1]}};
`else
        return {4'b0, b};
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_8"},  count8,          8'h00);
        check({tag, "_p4"}, count_p4,        8'h00);
        check({tag, "_w4"}, {4'b0, count_w4}, 8'h00);
    endtask

    task automatic check_all(input int k);
        check("seq8",  count8,           enc8(k));
        check("seqp4", count_p4,         enc8(k / 4));
        check("seqw4", {4'b0, count_w4}, enc4(k));
`ifdef COUNT_GRAY_EN
        check("gray_hd",   8'($countones(prev8 ^ count8)), 8'd1);
        check("gray2bin",  8'(gray2bin(32'(count8))),       8'(k % 256));
        prev8 = count8;
`endif
    endtask

    initial begin
        reset = 1'b1;
        prev8 = 8'h00;

        // power-up reset, roughly 200 ns
        #1;
        check_zero("por_t0");
        repeat (7) begin
            @(negedge clk);
            check_zero("por_hold");
        end

        // release between edges; first posedge afterwards is active edge 1
        reset = 1'b0;
        n = 0;
        prev8 = 8'h00;
        repeat (367) begin
            @(negedge clk);
            n++;
            check_all(n);
            if (n == 1)   check("first_edge", count8, enc8(1));
            if (n == 255) check("at_255",     count8, enc8(255));
            if (n == 256) check("wrap_256",   count8, enc8(0));
        end
        check("after_367", count8, enc8(111));

        // asynchronous mid-run reset: must clear before the next edge
        #5;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        repeat (4257) begin
            @(negedge clk);
            check_zero("rst_hold");
        end

        // restart: sequence resumes from 0 exactly as after power-up
        reset = 1'b0;
        n = 0;
        prev8 = 8'h00;
        repeat (20) begin
            @(negedge clk);
            n++;
            check_all(n);
            if (n == 3)  check("p4_hold3",  count_p4, enc8(0));
            if (n == 4)  check("p4_step4",  count_p4, enc8(1));
            if (n == 7)  check("p4_hold7",  count_p4, enc8(1));
            if (n == 8)  check("p4_step8",  count_p4, enc8(2));
            if (n == 15) check("w4_at15",   {4'b0, count_w4}, enc4(15));
            if (n == 16) check("w4_wrap16", {4'b0, count_w4}, enc4(0));
        end
        check("w4_after20", {4'b0, count_w4}, enc4(4));
        check("restart20",  count8,           enc8(20));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
